// File: rtl/arm_pic_packer.sv
// ARM picture-write front end: synchronises the ARM strobe, packs 16-bit words into RGB888 pixels, buffers them for the SDRAM FIFO.
// Optional ARM_PIC_CKSUM_EN adds a running 16-bit sum of captured words on cksum.
module arm_pic_packer #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int PIX_CNT_W   = 24
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wen,
  input  logic [PIX_CNT_W-1:0] frame_pix,
  input  logic                 arm_pic_wr,
  input  logic [15:0]          arm_pic_wdata,
  output logic                 pix_valid,
  output logic [23:0]          pix_data,
  output logic                 pix_last,
  input  logic                 pix_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf
`ifdef ARM_PIC_CKSUM_EN
  ,output logic [15:0]         cksum
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_state_next;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_d;
  logic                   r_wen_d;
  logic [PIX_CNT_W-1:0]   r_frame_pix, r_pix_cnt;
  logic [1:0]             r_phase;
  logic [15:0]            r_hold;
  logic                   r_push, r_push_last;
  logic [23:0]            r_push_data;
  logic [24:0]            r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [AW:0]            r_count;
  logic                   r_ovf;

  logic                 w_rise, w_wen_rise, w_cap, w_emit, w_is_last;
  logic [PIX_CNT_W-1:0] w_cnt_inc;
  logic                 w_full, w_pop, w_wr, w_wr_ok, w_head_last;

  assign w_rise     = r_sync[SYNC_STAGES-1] & ~r_sync_d;
  assign w_wen_rise = wen & ~r_wen_d;
  assign w_cap      = (r_state == S_ACTIVE) && w_rise && wen && (r_frame_pix != '0);
  assign w_emit     = w_cap && (r_phase != 2'd0);
  assign w_cnt_inc  = r_pix_cnt + PIX_CNT_W'(1);
  assign w_is_last  = (w_cnt_inc == r_frame_pix);

  assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
  assign pix_valid   = (r_count != '0);
  assign w_pop       = pix_valid & pix_ready;
  assign w_wr        = r_push && ((r_state == S_ACTIVE) || (r_state == S_DRAIN));
  assign w_wr_ok     = w_wr && (!w_full || w_pop);
  assign w_head_last = r_mem[r_rd_ptr][24];
  assign pix_data    = pix_valid ? r_mem[r_rd_ptr][23:0] : 24'h0;
  assign pix_last    = pix_valid & w_head_last;
  assign ovf         = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE:   if (w_wen_rise) w_state_next = S_ACTIVE;
      S_ACTIVE: begin
        busy = 1'b1;
        if (r_frame_pix == '0)          w_state_next = S_DONE;
        else if (w_emit && w_is_last)   w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        // An empty buffer with nothing in flight also ends the drain, covering a dropped last pixel.
        if ((w_pop && w_head_last) || (r_count == '0 && !r_push)) w_state_next = S_DONE;
      end
      S_DONE:   done = 1'b1;
      default:  w_state_next = S_IDLE;
    endcase
    if (!wen) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync      <= '0;
      r_sync_d    <= 1'b0;
      r_wen_d     <= 1'b0;
      r_frame_pix <= '0;
      r_pix_cnt   <= '0;
      r_phase     <= 2'd0;
      r_hold      <= 16'h0;
      r_push      <= 1'b0;
      r_push_last <= 1'b0;
      r_push_data <= 24'h0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], arm_pic_wr};
      r_sync_d <= r_sync[SYNC_STAGES-1];
      r_wen_d  <= wen;
      if (!wen || w_wen_rise) begin
        r_phase   <= 2'd0;
        r_pix_cnt <= '0;
        r_push    <= 1'b0;
        if (w_wen_rise) r_frame_pix <= frame_pix;
      end else begin
        r_push <= w_emit;
        if (w_cap) begin
          case (r_phase)
            2'd0: begin
              r_hold  <= arm_pic_wdata;
              r_phase <= 2'd1;
            end
            2'd1: begin
              r_push_data <= {r_hold, arm_pic_wdata[15:8]};
              r_hold[7:0] <= arm_pic_wdata[7:0];
              r_phase     <= 2'd2;
            end
            default: begin
              r_push_data <= {r_hold[7:0], arm_pic_wdata};
              r_phase     <= 2'd0;
            end
          endcase
          if (w_emit) begin
            r_pix_cnt   <= w_cnt_inc;
            r_push_last <= w_is_last;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= {r_push_last, r_push_data};
  end

  always_ff @(posedge clk) begin
    if (rst || !wen) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      if (rst) r_ovf <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_ok, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_wen_rise)           r_ovf <= 1'b0;
      else if (w_wr && !w_wr_ok) r_ovf <= 1'b1;
    end
  end

`ifdef ARM_PIC_CKSUM_EN
  logic [15:0] r_cksum;
  always_ff @(posedge clk) begin
    if (rst)             r_cksum <= 16'h0;
    else if (w_wen_rise) r_cksum <= 16'h0;
    else if (w_cap)      r_cksum <= r_cksum + arm_pic_wdata;
  end
  assign cksum = r_cksum;
`endif

endmodule

// File: tb/tb_arm_pic_packer.sv
// Directed bench for arm_pic_packer: a packing model fills a pixel scoreboard, a monitor pops it on each handshake.
// Define ARM_PIC_CKSUM_EN to include the checksum step.
module tb_arm_pic_packer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, wen, arm_pic_wr, pix_ready;
  logic [23:0] frame_pix;
  logic [15:0] arm_pic_wdata;
  logic        pix_valid, pix_last, busy, done, ovf;
  logic [23:0] pix_data;
`ifdef ARM_PIC_CKSUM_EN
  logic [15:0] cksum;
`endif

  arm_pic_packer #(.SYNC_STAGES(2), .FIFO_DEPTH(DEPTH), .PIX_CNT_W(24)) dut (
    .clk(clk), .rst(rst), .wen(wen), .frame_pix(frame_pix),
    .arm_pic_wr(arm_pic_wr), .arm_pic_wdata(arm_pic_wdata),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last),
    .pix_ready(pix_ready), .busy(busy), .done(done), .ovf(ovf)
`ifdef ARM_PIC_CKSUM_EN
    , .cksum(cksum)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [24:0] q[$];
  int          m_occ, m_ph, m_cnt, m_frame;
  logic        m_active, m_ovf;
  logic [15:0] m_hold, m_ck;
  logic [7:0]  m_r1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Reference packer: pixels beyond the buffer capacity are dropped and flag ovf.
  task automatic model_word(input logic [15:0] w);
    logic [24:0] px;
    logic        emit;
    if (!m_active) return;
    m_ck = m_ck + w;
    emit = 1'b0;
    px   = '0;
    case (m_ph)
      0: begin m_hold = w; m_ph = 1; end
      1: begin px[23:0] = {m_hold, w[15:8]}; m_r1 = w[7:0]; m_ph = 2; emit = 1'b1; end
      default: begin px[23:0] = {m_r1, w}; m_ph = 0; emit = 1'b1; end
    endcase
    if (emit) begin
      m_cnt++;
      px[24] = (m_cnt == m_frame);
      if (px[24]) m_active = 1'b0;
      if (m_occ < DEPTH) begin q.push_back(px); m_occ++; end
      else m_ovf = 1'b1;
    end
  endtask

  task automatic arm_write(input logic [15:0] w);
    model_word(w);
    arm_pic_wdata = w;
    arm_pic_wr    = 1'b1;
    cyc(4);
    arm_pic_wr    = 1'b0;
    cyc(4);
  endtask

  task automatic start_pic(input int f);
    m_frame = f; m_active = (f != 0); m_ph = 0; m_cnt = 0; m_ck = 0; m_ovf = 1'b0;
    frame_pix = 24'(f);
    wen = 1'b1;
    cyc(2);
  endtask

  task automatic stop_pic();
    wen = 1'b0;
    q.delete(); m_occ = 0; m_active = 1'b0;
    cyc(1);
    check("valid_after_wen_fall", 32'(pix_valid), 0);
    check("busy_after_wen_fall", 32'(busy), 0);
    check("done_after_wen_fall", 32'(done), 0);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 200 && q.size() != 0; i++) cyc(1);
    check("scoreboard_drained", 32'(q.size()), 0);
    cyc(2);
  endtask

  always @(negedge clk) begin
    if (pix_valid && pix_ready) begin
      check("pix_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        logic [24:0] e;
        e = q.pop_front();
        m_occ--;
        check("pix_data_last", {7'h0, pix_last, pix_data}, {7'h0, e});
        $display("pixel %06h last=%0d", pix_data, pix_last);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wen = 1'b0; arm_pic_wr = 1'b0; arm_pic_wdata = 16'h0;
    pix_ready = 1'b1; frame_pix = 24'h0; m_occ = 0; m_active = 1'b0;
    m_ph = 0; m_cnt = 0; m_frame = 0; m_ovf = 1'b0; m_hold = 0; m_r1 = 0; m_ck = 0;
    cyc(3);
    check("rst_valid", 32'(pix_valid), 0);
    check("rst_data", 32'(pix_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ovf", 32'(ovf), 0);
    rst = 1'b0;
    cyc(2);

    // Two pixels from three words, last tagged on the second.
    start_pic(2);
    check("t1_busy", 32'(busy), 1);
    arm_write(16'h1122);
    arm_write(16'h3344);
    arm_write(16'h5566);
    wait_empty();
    check("t1_done", 32'(done), 1);
    check("t1_busy_end", 32'(busy), 0);
    stop_pic();

    // Frame of three pixels fed six words: extra words are ignored.
    start_pic(3);
    for (int i = 0; i < 6; i++) arm_write(16'(16'hA000 + i * 16'h0111));
    wait_empty();
    check("t2_done", 32'(done), 1);
    check("t2_busy", 32'(busy), 0);
    check("t2_ovf", 32'(ovf), 0);
    stop_pic();

    // Consumer stalled: buffer fills, later pixels dropped.
    pix_ready = 1'b0;
    start_pic(100);
    for (int i = 0; i < 9; i++) arm_write(16'(16'h1000 + i * 16'h1357));
    check("t3_ovf", 32'(ovf), 32'(m_ovf));
    check("t3_valid", 32'(pix_valid), 1);
    check("t3_busy", 32'(busy), 1);
    pix_ready = 1'b1;
    wait_empty();
    check("t3_empty", 32'(pix_valid), 0);
    stop_pic();
    check("t3_ovf_held", 32'(ovf), 1);

    // Abort mid-group, then restart with fresh packing.
    start_pic(10);
    check("t4_ovf_cleared", 32'(ovf), 0);
    arm_write(16'hDEAD);
    arm_write(16'hBEEF);
    wait_empty();
    stop_pic();
    start_pic(10);
    arm_write(16'h0102);
    arm_write(16'h0304);
    arm_write(16'h0506);
    wait_empty();
    check("t4_busy", 32'(busy), 1);
    stop_pic();

    // Empty frame completes immediately.
    start_pic(0);
    check("t5_done", 32'(done), 1);
    check("t5_valid", 32'(pix_valid), 0);
    arm_write(16'h7777);
    check("t5_valid_after_wr", 32'(pix_valid), 0);
    stop_pic();

`ifdef ARM_PIC_CKSUM_EN
    start_pic(10);
    arm_write(16'hFFFF);
    arm_write(16'h0002);
    arm_write(16'h0001);
    wait_empty();
    check("t6_cksum", 32'(cksum), 32'(m_ck));
    stop_pic();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
